// File: rtl/rom_ctrl_scan_counter.sv
// rom_ctrl_scan_counter
//
// Walks the ROM address space from 0 to RomDepth-1 once per scan. It issues
// read requests and flags each word on the ROM output. The top RomTopCount
// words hold the expected hash, and the word just below them is the last
// non-top word.
//
// Handshake: a word is transferred on a cycle where data_vld_o and
// data_rdy_i are both high while the scan is running ("go"). The valid
// signal never drops on its own. Without data_rdy_i the address, the flags
// and read_addr_o all hold, and the ROM output buffer keeps the word
// stable. read_addr_o looks one address ahead on go. This lets the ROM
// present the next word on the following cycle, so words stream with no
// bubble.
//
// Parameters:
//   RomDepth    - number of ROM words (must be >= RomTopCount + 2)
//   RomTopCount - number of hash words at the top (1 <= RomTopCount < RomDepth)
//   AutoStart   - 1: scan starts on the first clock after reset
//                 0: scan waits for start_i
//
// Ports:
//   clk_i              - clock
//   rst_ni             - asynchronous active-low reset
//   start_i            - request a (re)scan from address 0 (ignored mid-scan)
//   data_rdy_i         - consumer ready for the current word
//   read_req_o         - ROM read request, high throughout the scan
//   read_addr_o        - ROM read address
//   data_vld_o         - ROM output word is valid for data_addr_o
//   data_addr_o        - address of the word on the ROM output
//   data_last_nontop_o - current word is the last non-top word
//   data_top_o         - current word is a top (hash) word
//   busy_o             - scan in progress
//   done_o             - scan complete, sticky until the next start
//   dbg_state_o        - FSM state (0 idle, 1 scan, 2 done)

module rom_ctrl_scan_counter #(
  parameter int RomDepth    = 16,
  parameter int RomTopCount = 2,
  parameter bit AutoStart   = 1'b1,
  localparam int AW         = (RomDepth <= 1) ? 1 : $clog2(RomDepth)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          data_rdy_i,
  output logic          read_req_o,
  output logic [AW-1:0] read_addr_o,
  output logic          data_vld_o,
  output logic [AW-1:0] data_addr_o,
  output logic          data_last_nontop_o,
  output logic          data_top_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [1:0]    dbg_state_o
);

  localparam logic [AW-1:0] TopAddr      = AW'(RomDepth - 1);
  localparam logic [AW-1:0] LastNTAddr   = AW'(RomDepth - RomTopCount - 1);
  localparam logic [AW-1:0] FirstTopAddr = AW'(RomDepth - RomTopCount);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StScan = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          vld_q, vld_d;
  logic          last_nt_q, last_nt_d;
  logic          top_q, top_d;
  logic          done_q, done_d;

  logic          go;
  logic          at_top;
  logic          enter_scan;
  logic [AW-1:0] addr_inc;

  assign go         = data_rdy_i & vld_q & (state_q == StScan);
  assign at_top     = (addr_q == TopAddr);
  // The scan is left at TopAddr, so this never needs to reach RomDepth.
  assign addr_inc   = addr_q + AW'(1);
  assign enter_scan = (state_q != StScan) && (state_d == StScan);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // IDLE is only reachable through reset. So with AutoStart, leaving it
      // unconditionally means leaving on the first clock after reset.
      StIdle: if (start_i || AutoStart) state_d = StScan;
      StScan: if (go && at_top)         state_d = StDone;
      StDone: if (start_i)              state_d = StScan;
      default:                          state_d = StIdle;
    endcase
  end

  // Datapath next-state: address counter, valid and word flags
  always_comb begin
    addr_d    = addr_q;
    vld_d     = vld_q;
    last_nt_d = last_nt_q;
    top_d     = top_q;
    done_d    = (state_d == StDone);
    if (enter_scan) begin
      addr_d    = '0;
      vld_d     = 1'b0;
      last_nt_d = 1'b0;
      top_d     = 1'b0;
    end else if (state_q == StScan) begin
      // The first read is issued on scan entry, so the word is valid from
      // the next cycle until the top word is handed over.
      vld_d = !(go && at_top);
      if (go && !at_top) begin
        addr_d    = addr_inc;
        last_nt_d = (addr_inc == LastNTAddr);
        top_d     = top_q | (addr_inc == FirstTopAddr);
      end
    end else begin
      vld_d = 1'b0;
      if (state_q == StIdle) top_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      vld_q     <= 1'b0;
      last_nt_q <= 1'b0;
      top_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      vld_q     <= vld_d;
      last_nt_q <= last_nt_d;
      top_q     <= top_d;
      done_q    <= done_d;
    end
  end

  // Outputs
  always_comb begin
    read_req_o         = (state_q == StScan);
    busy_o             = (state_q == StScan);
    read_addr_o        = go ? addr_inc : addr_q;
    data_vld_o         = vld_q;
    data_addr_o        = addr_q;
    data_last_nontop_o = last_nt_q;
    data_top_o         = top_q;
    done_o             = done_q;
    dbg_state_o        = state_q;
  end

endmodule

// File: tb/tb_rom_ctrl_scan_counter.sv
// Bench for rom_ctrl_scan_counter. It drives three instances:
//   u_a: defaults (16 words, 2 top words, AutoStart=1)
//   u_b: AutoStart=0
//   u_c: 5 words, 3 top words
// The reference is a queue of the addresses still owed by the current scan.
// A word is valid from the cycle after scan entry. Each handshake pops the
// head. Flags follow from address arithmetic alone.

module tb_rom_ctrl_scan_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [3];
  logic       start [3];
  logic       rdy   [3];
  logic       req   [3];
  logic       vld   [3];
  logic       lnt   [3];
  logic       top   [3];
  logic       busy  [3];
  logic       done  [3];
  logic [1:0] st    [3];
  logic [3:0] a_raddr, a_daddr, b_raddr, b_daddr;
  logic [2:0] c_raddr, c_daddr;

  int checks = 0;
  int errors = 0;

  rom_ctrl_scan_counter u_a (
    .clk_i(clk), .rst_ni(rst_n[0]), .start_i(start[0]), .data_rdy_i(rdy[0]),
    .read_req_o(req[0]), .read_addr_o(a_raddr), .data_vld_o(vld[0]),
    .data_addr_o(a_daddr), .data_last_nontop_o(lnt[0]), .data_top_o(top[0]),
    .busy_o(busy[0]), .done_o(done[0]), .dbg_state_o(st[0])
  );

  rom_ctrl_scan_counter #(.AutoStart(1'b0)) u_b (
    .clk_i(clk), .rst_ni(rst_n[1]), .start_i(start[1]), .data_rdy_i(rdy[1]),
    .read_req_o(req[1]), .read_addr_o(b_raddr), .data_vld_o(vld[1]),
    .data_addr_o(b_daddr), .data_last_nontop_o(lnt[1]), .data_top_o(top[1]),
    .busy_o(busy[1]), .done_o(done[1]), .dbg_state_o(st[1])
  );

  rom_ctrl_scan_counter #(.RomDepth(5), .RomTopCount(3)) u_c (
    .clk_i(clk), .rst_ni(rst_n[2]), .start_i(start[2]), .data_rdy_i(rdy[2]),
    .read_req_o(req[2]), .read_addr_o(c_raddr), .data_vld_o(vld[2]),
    .data_addr_o(c_daddr), .data_last_nontop_o(lnt[2]), .data_top_o(top[2]),
    .busy_o(busy[2]), .done_o(done[2]), .dbg_state_o(st[2])
  );

  typedef struct {
    int req, vld, busy, done, lnt, top, daddr, raddr;
  } obs_t;

  typedef struct {
    bit start, rdy;
    int req, vld, busy, done, daddr, raddr;
  } vec_t;

  function automatic obs_t get_obs(input int inst);
    obs_t o;
    o.req  = int'(req[inst]);
    o.vld  = int'(vld[inst]);
    o.busy = int'(busy[inst]);
    o.done = int'(done[inst]);
    o.lnt  = int'(lnt[inst]);
    o.top  = int'(top[inst]);
    case (inst)
      0:       begin o.daddr = int'(a_daddr); o.raddr = int'(a_raddr); end
      1:       begin o.daddr = int'(b_daddr); o.raddr = int'(b_raddr); end
      default: begin o.daddr = int'(c_daddr); o.raddr = int'(c_raddr); end
    endcase
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input int inst, input string tag);
    obs_t o;
    o = get_obs(inst);
    chk($sformatf("%s_req i%0d", tag, inst),   o.req,   0);
    chk($sformatf("%s_vld i%0d", tag, inst),   o.vld,   0);
    chk($sformatf("%s_busy i%0d", tag, inst),  o.busy,  0);
    chk($sformatf("%s_done i%0d", tag, inst),  o.done,  0);
    chk($sformatf("%s_lnt i%0d", tag, inst),   o.lnt,   0);
    chk($sformatf("%s_top i%0d", tag, inst),   o.top,   0);
    chk($sformatf("%s_daddr i%0d", tag, inst), o.daddr, 0);
    chk($sformatf("%s_raddr i%0d", tag, inst), o.raddr, 0);
  endtask

  // Entered at the negedge of the first SCAN cycle; returns at the negedge
  // after the first DONE cycle has been checked.
  task automatic check_scan(input int inst, input int depth, input int topcnt,
                            input int rdy_pct, input bit poke);
    int   exp_q[$];
    int   c, a, last_nt, mask;
    bit   go;
    obs_t o;
    for (int i = 0; i < depth; i++) exp_q.push_back(i);
    last_nt = depth - topcnt - 1;
    mask    = (1 << $clog2(depth)) - 1;
    c       = 0;
    while (exp_q.size() > 0) begin
      if (c > 2000) begin
        chk($sformatf("scan_timeout i%0d", inst), 1, 0);
        return;
      end
      rdy[inst]   = ($urandom_range(0, 99) < rdy_pct);
      start[inst] = poke && (c == 5);
      #1;
      o  = get_obs(inst);
      a  = exp_q[0];
      go = rdy[inst] && (c > 0);
      chk($sformatf("scan_req i%0d c%0d", inst, c),   o.req,   1);
      chk($sformatf("scan_busy i%0d c%0d", inst, c),  o.busy,  1);
      chk($sformatf("scan_done i%0d c%0d", inst, c),  o.done,  0);
      chk($sformatf("scan_vld i%0d c%0d", inst, c),   o.vld,   int'(c > 0));
      chk($sformatf("scan_daddr i%0d c%0d", inst, c), o.daddr, a);
      chk($sformatf("scan_raddr i%0d c%0d", inst, c), o.raddr, go ? ((a + 1) & mask) : a);
      chk($sformatf("scan_lnt i%0d c%0d", inst, c),   o.lnt,   int'(a == last_nt));
      chk($sformatf("scan_top i%0d c%0d", inst, c),   o.top,   int'(a > last_nt));
      if (go) void'(exp_q.pop_front());
      c++;
      @(negedge clk);
    end
    start[inst] = 1'b0;
    #1;
    o = get_obs(inst);
    chk($sformatf("end_done i%0d", inst),  o.done,  1);
    chk($sformatf("end_busy i%0d", inst),  o.busy,  0);
    chk($sformatf("end_req i%0d", inst),   o.req,   0);
    chk($sformatf("end_vld i%0d", inst),   o.vld,   0);
    chk($sformatf("end_daddr i%0d", inst), o.daddr, depth - 1);
    chk($sformatf("end_top i%0d", inst),   o.top,   1);
    chk($sformatf("end_lnt i%0d", inst),   o.lnt,   0);
    @(negedge clk);
  endtask

  // Pulse start_i for one cycle while in DONE; returns at the first SCAN negedge.
  task automatic restart(input int inst);
    obs_t o;
    start[inst] = 1'b1;
    #1;
    o = get_obs(inst);
    chk($sformatf("pre_start_done i%0d", inst), o.done, 1);
    @(negedge clk);
    start[inst] = 1'b0;
  endtask

  // Cycle 0 after reset release: still idle.
  task automatic release_rst(input int inst);
    obs_t o;
    rst_n[inst] = 1'b1;
    rdy[inst]   = 1'b1;
    #1;
    o = get_obs(inst);
    chk($sformatf("cyc0_req i%0d", inst),  o.req,  0);
    chk($sformatf("cyc0_busy i%0d", inst), o.busy, 0);
    @(negedge clk);
  endtask

  vec_t tbl[12];
  obs_t o;
  bit   hit;

  initial begin
    // {start, rdy, req, vld, busy, done, daddr, raddr} for the AutoStart=0 instance
    tbl[0]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 1, 0, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 1, 1, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 1, 1, 1, 0, 0, 0};
    tbl[7]  = '{0, 1, 1, 1, 1, 0, 0, 1};
    tbl[8]  = '{0, 1, 1, 1, 1, 0, 1, 2};
    tbl[9]  = '{0, 0, 1, 1, 1, 0, 2, 2};
    tbl[10] = '{1, 1, 1, 1, 1, 0, 2, 3};
    tbl[11] = '{0, 1, 1, 1, 1, 0, 3, 4};

    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      start[i] = 1'b0;
      rdy[i]   = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_idle(i, "reset");

    // AutoStart=0: idle until start_i, stalls hold, mid-scan start ignored
    rst_n[1] = 1'b1;
    for (int r = 0; r < 12; r++) begin
      start[1] = tbl[r].start;
      rdy[1]   = tbl[r].rdy;
      #1;
      o = get_obs(1);
      chk($sformatf("tbl_req r%0d", r),   o.req,   tbl[r].req);
      chk($sformatf("tbl_vld r%0d", r),   o.vld,   tbl[r].vld);
      chk($sformatf("tbl_busy r%0d", r),  o.busy,  tbl[r].busy);
      chk($sformatf("tbl_done r%0d", r),  o.done,  tbl[r].done);
      chk($sformatf("tbl_daddr r%0d", r), o.daddr, tbl[r].daddr);
      chk($sformatf("tbl_raddr r%0d", r), o.raddr, tbl[r].raddr);
      @(negedge clk);
    end
    rst_n[1] = 1'b0;
    start[1] = 1'b0;
    rdy[1]   = 1'b0;
    #1;
    chk_idle(1, "b_abort");
    @(negedge clk);

    // Defaults: full-rate scan, then stalled rescans
    release_rst(0);
    check_scan(0, 16, 2, 100, 1'b0);
    rdy[0] = 1'b1;
    repeat (3) begin
      #1;
      o = get_obs(0);
      chk("done_sticky", o.done, 1);
      chk("done_addr", o.daddr, 15);
      chk("done_vld", o.vld, 0);
      @(negedge clk);
    end
    restart(0);
    check_scan(0, 16, 2, 60, 1'b1);
    restart(0);
    check_scan(0, 16, 2, 30, 1'b0);

    // Reset at address 7 aborts the scan; AutoStart rescans from 0
    restart(0);
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      rdy[0] = 1'($urandom_range(0, 1));
      #1;
      o = get_obs(0);
      if (o.vld == 1 && o.daddr == 7) hit = 1'b1;
      else @(negedge clk);
    end
    chk("reach_addr7", int'(hit), 1);
    rst_n[0] = 1'b0;
    #1;
    chk_idle(0, "a_rst_mid");
    @(negedge clk);
    release_rst(0);
    check_scan(0, 16, 2, 70, 1'b0);

    // Minimum non-top region
    release_rst(2);
    check_scan(2, 5, 3, 100, 1'b0);
    restart(2);
    check_scan(2, 5, 3, 50, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rom_ctrl_scan_counter.md
ROM_CTRL_SCAN_COUNTER -- requirements
Module: rom_ctrl_scan_counter

Interface
REQ-001 Parameter RomDepth, default 16, number of ROM words; SHALL be at least RomTopCount+2.
REQ-002 Parameter RomTopCount, default 2, number of top words (expected hash) at the top of the address space; SHALL satisfy 1 <= RomTopCount < RomDepth.
REQ-003 Parameter AutoStart, default 1'b1; 1 = scan begins automatically after reset, 0 = scan waits for start_i.
REQ-004 AW SHALL equal vbits(RomDepth). TopAddr SHALL equal RomDepth-1. LastNTAddr SHALL equal RomDepth-RomTopCount-1.
REQ-005 clk_i  input  1  clock.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 start_i  input  1  request a (re)scan from address 0.
REQ-008 data_rdy_i  input  1  consumer ready for the current word.
REQ-009 read_req_o  output  1  ROM read request.
REQ-010 read_addr_o  output  AW  ROM read address.
REQ-011 data_vld_o  output  1  ROM output word is valid for the address on data_addr_o.
REQ-012 data_addr_o  output  AW  address of the word currently on the ROM output.
REQ-013 data_last_nontop_o  output  1  current word is the last non-top word.
REQ-014 data_top_o  output  1  current word is a top (hash) word.
REQ-015 busy_o  output  1  scan in progress.
REQ-016 done_o  output  1  scan complete; sticky until the next start.

Function
REQ-017 FSM states SHALL be IDLE, SCAN and DONE, with a registered state.
REQ-018 IDLE -> SCAN SHALL occur when start_i=1, or unconditionally on the first clock after reset when AutoStart=1.
REQ-019 On entry to SCAN, addr_q SHALL be set to 0 and vld_q SHALL be set to 0.
REQ-020 read_req_o SHALL be 1 exactly while the state is SCAN.
REQ-021 vld_q SHALL go to 1 one cycle after read_req_o rises and SHALL stay 1 throughout SCAN. data_vld_o SHALL equal vld_q.
REQ-022 go SHALL equal data_rdy_i & data_vld_o & (state==SCAN).
REQ-023 read_addr_o SHALL equal go ? addr_q+1 : addr_q. Arithmetic SHALL be AW bits wide, with no wrap, because go never fires at TopAddr+1.
REQ-024 On go with addr_q != TopAddr, addr_q SHALL increment by 1 and data_vld_o SHALL stay 1, so back-to-back words stream with no bubble.
REQ-025 On go with addr_q == TopAddr, the FSM SHALL go SCAN -> DONE; data_vld_o and read_req_o SHALL be 0 from the next cycle.
REQ-026 data_addr_o SHALL equal addr_q.
REQ-027 data_last_nontop_o SHALL be registered: set when advancing into LastNTAddr, cleared on any other advance or on entry to SCAN.
REQ-028 data_top_o SHALL be registered: set when advancing into LastNTAddr+1, held until entry to SCAN or IDLE.
REQ-029 Without data_rdy_i, addr_q, the flags and read_addr_o SHALL hold indefinitely (the ROM output buffer holds the data).
REQ-030 done_o SHALL be registered (state==DONE). In DONE, addr_q SHALL remain at TopAddr.
REQ-031 start_i in DONE SHALL cause DONE -> SCAN, with done_o low the next cycle.
REQ-032 start_i in SCAN SHALL be ignored; a scan is never restarted mid-way.
REQ-033 busy_o SHALL equal (state==SCAN).

Reset
REQ-034 On rst_ni low, asynchronously: state=IDLE, addr_q=0, vld_q=0, all flags=0, done_o=0, read_req_o=0, busy_o=0.
REQ-035 Reset asserted mid-scan SHALL abort the scan immediately. With AutoStart=1, the scan SHALL restart from address 0 after release.

Verification
REQ-036 Defaults, data_rdy_i held 1 from reset -> read_req_o=1 at cycle 1; data_vld_o=1 at cycle 2; addresses 0..15 delivered on consecutive cycles; data_last_nontop_o=1 only at address 13; data_top_o=1 at addresses 14-15; done_o=1 the cycle after the handshake at address 15.
REQ-037 Random data_rdy_i stalls -> every address 0..TopAddr handshaked exactly once, in order; read_addr_o changes only on go.
REQ-038 AutoStart=0 -> outputs stay at reset values until start_i pulses; scan then begins with read_req_o=1 the next cycle.
REQ-039 start_i pulse in DONE -> done_o=0 next cycle and a second full scan from address 0. start_i pulse mid-SCAN -> no effect on the address sequence.
REQ-040 rst_ni asserted at address 7 -> all outputs at reset values immediately; with AutoStart=1, a rescan from 0 after release.
REQ-041 RomDepth=5, RomTopCount=3 (minimum non-top) -> data_last_nontop_o at address 1; data_top_o at addresses 2-4; done_o after address 4.
